fp_adder: RTL and testbench

FP_ADDER -- requirements
Module: fp_adder

---
 rtl/fp_adder_pkg.sv | 34 +++
 rtl/fp_lzc24.sv | 22 ++
 rtl/fp_adder.sv | 109 ++++++++++
 tb/tb_fp_adder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_adder_pkg.sv
// +----------------------------------------------------------------------------+
// | fp_adder_pkg : binary32 format constants, unpacked operand type, unpacker   |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp_adder_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int SIG_W   = 24;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  sig;
    } fp_operand_t;

    // Exponent-zero encodings (zero and denormals) collapse to a zero significand.
    function automatic fp_operand_t unpack(input logic [31:0] x);
        fp_operand_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.sig  = (x[30:23] == '0) ? '0 : {1'b1, x[FRAC_W-1:0]};
        return u;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_lzc24.sv
// +----------------------------------------------------------------------------+
// | fp_lzc24 : 24-bit leading-zero counter, returns 24 for an all-zero input    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_adder.sv
// +----------------------------------------------------------------------------+
// | fp_adder : binary32 adder, truncating, denormals flushed, one register stage|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_adder
    import fp_adder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    fp_operand_t        ua, ub, big;
    logic [EXP_W-1:0]   small_exp, exp_diff;
    logic [SIG_W-1:0]   small_sig, aligned, diff_sig, norm_sig;
    logic [SIG_W:0]     sum;
    logic [4:0]         lz;
    logic signed [9:0]  big_exp10, norm_exp;
    logic               a_nan, b_nan, a_inf, b_inf, same_sign, a_is_big;
    logic [31:0]        next_result;
    logic               next_ovf, next_unf;

    assign ua    = unpack(a);
    assign ub    = unpack(b);
    assign a_nan = (a[30:23] == 8'(EXP_MAX)) && (a[FRAC_W-1:0] != '0);
    assign b_nan = (b[30:23] == 8'(EXP_MAX)) && (b[FRAC_W-1:0] != '0);
    assign a_inf = (a[30:23] == 8'(EXP_MAX)) && (a[FRAC_W-1:0] == '0);
    assign b_inf = (b[30:23] == 8'(EXP_MAX)) && (b[FRAC_W-1:0] == '0);

    // Magnitude order on {exp, sig}; ties keep A as the larger operand.
    assign a_is_big  = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
    assign big       = a_is_big ? ua : ub;
    assign small_exp = a_is_big ? ub.exp : ua.exp;
    assign small_sig = a_is_big ? ub.sig : ua.sig;
    assign same_sign = (ua.sign == ub.sign);

    assign exp_diff  = big.exp - small_exp;
    assign aligned   = (exp_diff >= 8'(SIG_W)) ? '0 : (small_sig >> exp_diff);
    assign sum       = {1'b0, big.sig} + {1'b0, aligned};
    assign diff_sig  = big.sig - aligned;
    assign big_exp10 = signed'({2'b00, big.exp});

    fp_lzc24 u_lzc (
        .value (diff_sig),
        .count (lz)
    );

    always_comb begin
        next_result = '0;
        next_ovf    = 1'b0;
        next_unf    = 1'b0;
        norm_sig    = '0;
        norm_exp    = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            next_result = QNAN;
        end else if (a_inf) begin
            next_result = a;
        end else if (b_inf) begin
            next_result = b;
        end else begin
            if (same_sign) begin
                if (sum[SIG_W]) begin
                    norm_sig = sum[SIG_W:1];
                    norm_exp = big_exp10 + 10'sd1;
                end else begin
                    norm_sig = sum[SIG_W-1:0];
                    norm_exp = big_exp10;
                end
            end else begin
                norm_sig = diff_sig << lz;
                norm_exp = big_exp10 - signed'({5'd0, lz});
            end

            // A zero sum keeps its sign only when both inputs were same-signed zeros.
            if (norm_sig == '0) begin
                next_result = {same_sign & big.sign, 31'd0};
            end else if (norm_exp > 10'sd254) begin
                next_result = {big.sign, 8'hFF, 23'd0};
                next_ovf    = 1'b1;
            end else if (norm_exp < 10'sd1) begin
                next_result = {big.sign, 31'd0};
                next_unf    = 1'b1;
            end else begin
                next_result = {big.sign, norm_exp[EXP_W-1:0], norm_sig[FRAC_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            result    <= next_result;
            overflow  <= next_ovf;
            underflow <= next_unf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_adder.sv
// +----------------------------------------------------------------------------+
// | tb_fp_adder : scoreboard bench for fp_adder with directed and random ops    |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fp_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        overflow, underflow;
    logic        in_valid = 1'b0;

    logic [33:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    fp_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Directed vectors: a, b, expected {overflow, underflow, result}
    logic [31:0] dir_a[14] = '{32'hC1040001, 32'hC1040201, 32'hC0A40201, 32'h43A40201,
                               32'h7F240201, 32'h00A40201, 32'h3F800000, 32'h7FC00001,
                               32'h7F800000, 32'h7F800000, 32'hFF800000, 32'h80000000,
                               32'h00000000, 32'h00000001};
    logic [31:0] dir_b[14] = '{32'hC1008001, 32'h41008001, 32'h40008001, 32'h3F008001,
                               32'h7F008001, 32'h80A08102, 32'hBF800000, 32'h3F800000,
                               32'hFF800000, 32'h3F800000, 32'hFF800000, 32'h80000000,
                               32'h80000000, 32'h3F800000};
    logic [33:0] dir_e[14] = '{{2'b00, 32'hC1824001}, {2'b00, 32'hBE608000},
                               {2'b00, 32'hC0478402}, {2'b00, 32'h43A44241},
                               {2'b10, 32'h7F800000}, {2'b01, 32'h00000000},
                               {2'b00, 32'h00000000}, {2'b00, 32'h7FC00000},
                               {2'b00, 32'h7FC00000}, {2'b00, 32'h7F800000},
                               {2'b00, 32'hFF800000}, {2'b00, 32'h80000000},
                               {2'b00, 32'h00000000}, {2'b00, 32'h3F800000}};

    // Reference model: integer significands, loop-based normalisation.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
        int     ex, ey, eb, es, e, d;
        longint mx, my, mb, ms, v;
        bit     sx, sy, sb, same;
        ex = int'(x[30:23]);  ey = int'(y[30:23]);
        sx = x[31];           sy = y[31];
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
            (ex == 255 && ey == 255 && sx != sy))
            return {2'b00, 32'h7FC00000};
        if (ex == 255) return {2'b00, x};
        if (ey == 255) return {2'b00, y};
        mx = (ex == 0) ? 0 : (longint'(1) << 23) + longint'(x[22:0]);
        my = (ey == 0) ? 0 : (longint'(1) << 23) + longint'(y[22:0]);
        if (ey > ex || (ey == ex && my > mx)) begin
            eb = ey; mb = my; sb = sy; es = ex; ms = mx;
        end else begin
            eb = ex; mb = mx; sb = sx; es = ey; ms = my;
        end
        same = (sx == sy);
        d    = eb - es;
        ms   = (d >= 24) ? 0 : (ms >> d);
        v    = same ? mb + ms : mb - ms;
        if (v == 0) return {2'b00, (same && sb), 31'd0};
        e = eb;
        while (v >= (longint'(1) << 24)) begin v = v >> 1; e++; end
        while (v <  (longint'(1) << 23)) begin v = v << 1; e--; end
        if (e > 254) return {2'b10, sb, 8'hFF, 23'd0};
        if (e < 1)   return {2'b01, sb, 31'd0};
        return {2'b00, sb, 8'(e), 23'(v)};
    endfunction

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got result=%h ovf=%b unf=%b, want result=%h ovf=%b unf=%b",
                     name, got[31:0], got[33], got[32], want[31:0], want[33], want[32]);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [33:0] want);
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        exp_q.push_back(want);
    endtask

    function automatic logic [31:0] rand_op(input logic [7:0] near);
        int unsigned sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        if (sel == 0) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
        end else if (sel == 1) e = 8'h00;
        else if (sel <= 3)     e = 8'($urandom_range(0, 255));
        else if (sel == 4)     e = 8'($urandom_range(248, 254));
        else if (sel == 5)     e = 8'($urandom_range(1, 8));
        else                   e = near + 8'($urandom_range(0, 26)) - 8'd13;
        return {1'($urandom), e, f};
    endfunction

    // Monitor: an output is due one cycle after every accepted input.
    initial begin
        bit fire;
        forever begin
            @(posedge clk);
            fire = in_valid && rst_n;
            #1;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underrun: got result=%h, want no output pending", result);
                end else begin
                    check("sb", {overflow, underflow, result}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] x, y;
        #12;
        check("reset", {overflow, underflow, result}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) issue(dir_a[i], dir_b[i], dir_e[i]);

        // Mid-stream reset: a nonzero result is on the outputs and another op is in flight.
        issue(32'h3F800000, 32'h40000000, model(32'h3F800000, 32'h40000000));
        issue(32'h40400000, 32'h40400000, model(32'h40400000, 32'h40400000));
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset", {overflow, underflow, result}, 34'd0);
        @(posedge clk);
        #1;
        check("reset_hold", {overflow, underflow, result}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 6; i < 14; i++) issue(dir_a[i], dir_b[i], dir_e[i]);

        for (int i = 0; i < 600; i++) begin
            x = rand_op(8'($urandom_range(1, 254)));
            case ($urandom_range(0, 7))
                0:       y = {~x[31], x[30:0]};
                1:       y = {~x[31], x[30:8], 8'($urandom)};
                2:       y = {~x[31], x[30:23], x[22:14], 14'($urandom)};
                default: y = rand_op(x[30:23]);
            endcase
            if ($urandom_range(0, 1) == 0) issue(x, y, model(x, y));
            else                           issue(y, x, model(y, x));
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
